// File: rtl/avr_frs_pipe_if.sv
// AVR stream port bundle for avr_frs_pipe.
// m_* is the upstream side of the pipe, s_* the downstream side.
// slave  : the view taken by the pipe itself.
// master : the view taken by whatever surrounds the pipe (source + sink).
interface avr_frs_pipe_if #(
  parameter int DW = 256
);
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;

  modport slave (
    input  m_data, m_valid, s_ready,
    output m_ready, s_data, s_valid
  );

  modport master (
    output m_data, m_valid, s_ready,
    input  m_ready, s_data, s_valid
  );
endinterface

// File: rtl/avr_frs_pipe.sv
// Forward register slice chain for AVR (valid/ready) streams.
// Valid and data are registered in every stage; ready is a combinational
// chain from s_ready back to m_ready so a full pipe still moves one beat
// per cycle. Empty stages keep accepting while downstream is stalled, so
// bubbles collapse.
// Optional build macro AVR_FRS_DATA_CLR_EN: a stage that drains without
// refill clears its data register, so s_data reads 0 whenever s_valid is 0.
module avr_frs_pipe #(
  parameter  int DW     = 256,
  parameter  int STAGES = 2,
  parameter  int CNT_W  = 16,
  localparam int OW     = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  avr_frs_pipe_if.slave    io,
  input  logic             clr_cnt,
  output logic [OW-1:0]    occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("avr_frs_pipe: STAGES must be in 1..8");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              vld [STAGES];
  logic [DW-1:0]     dat [STAGES];
  logic [STAGES-1:0] rdy;

  // Ready chain: a stage can load if it is empty or anything after it can move.
  always_comb begin
    logic acc;
    acc = io.s_ready;
    rdy = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc    = acc | ~vld[i];
      rdy[i] = acc;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic          up_vld;
    logic [DW-1:0] up_dat;

    if (i == 0) begin : g_head
      assign up_vld = io.m_valid;
      assign up_dat = io.m_data;
    end else begin : g_body
      assign up_vld = vld[i-1];
      assign up_dat = dat[i-1];
    end

    // Stage register: load from upstream when ready, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld[i] <= 1'b0;
        dat[i] <= '0;
      end else if (rdy[i]) begin
        vld[i] <= up_vld;
        if (up_vld)
          dat[i] <= up_dat;
`ifdef AVR_FRS_DATA_CLR_EN
        else
          dat[i] <= '0;
`endif
      end
    end
  end

  assign io.m_ready = rdy[0];
  assign io.s_valid = vld[STAGES-1];
  assign io.s_data  = dat[STAGES-1];

  // Occupancy is a popcount of the registered stage valids.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++)
      occupancy = occupancy + OW'(vld[i]);
  end

  // Saturating count of cycles where the output is blocked; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (clr_cnt)
      stall_cnt <= '0;
    else if (vld[STAGES-1] && !io.s_ready && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_avr_frs_pipe.sv
// Testbench for avr_frs_pipe (DW=16, STAGES=2, CNT_W=4).
module tb_avr_frs_pipe;
  localparam int DW     = 16;
  localparam int STAGES = 2;
  localparam int CNT_W  = 4;
  localparam int OW     = $clog2(STAGES + 1);
  localparam int NBEATS = 10000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr_cnt;
  logic [OW-1:0]    occupancy;
  logic [CNT_W-1:0] stall_cnt;

  avr_frs_pipe_if #(.DW(DW)) io ();

  avr_frs_pipe #(.DW(DW), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (io),
    .clr_cnt   (clr_cnt),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          mv;
    logic [15:0] d;
    bit          sr;
    bit          clr;
    bit          e_mr;
    bit          e_sv;
    logic [15:0] e_sd;
    int          e_occ;
    int          e_st;
  } vec_t;

  vec_t tbl [16];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    io.m_valid = 1'b0; io.m_data = '0; io.s_ready = 1'b0; clr_cnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] q[$];
    int          nxt, seen, acc_cnt, out_cnt, cyc, exp_st, exp_occ;
    bit          prev_hold;
    logic [15:0] prev_d, exp_d;

    rst_n = 1'b1;
    io.m_valid = 1'b0; io.m_data = '0; io.s_ready = 1'b0; clr_cnt = 1'b0;

    // mv, d, sr, clr | m_ready, s_valid, s_data, occupancy, stall_cnt
    tbl[0]  = '{0, 16'h00, 1, 0, 1, 0, 16'h00, 0, 0};
    tbl[1]  = '{1, 16'hA5, 1, 0, 1, 0, 16'h00, 0, 0};
    tbl[2]  = '{0, 16'h00, 1, 0, 1, 0, 16'h00, 1, 0};
    tbl[3]  = '{0, 16'h00, 1, 0, 1, 1, 16'hA5, 1, 0};
    tbl[4]  = '{0, 16'h00, 1, 0, 1, 0, 16'h00, 0, 0};
    tbl[5]  = '{1, 16'h11, 0, 0, 1, 0, 16'h00, 0, 0};
    tbl[6]  = '{1, 16'h22, 0, 0, 1, 0, 16'h00, 1, 0};
    tbl[7]  = '{1, 16'h33, 0, 0, 0, 1, 16'h11, 2, 0};
    tbl[8]  = '{1, 16'h33, 0, 0, 0, 1, 16'h11, 2, 1};
    tbl[9]  = '{1, 16'h33, 0, 0, 0, 1, 16'h11, 2, 2};
    tbl[10] = '{1, 16'h33, 1, 0, 1, 1, 16'h11, 2, 3};
    tbl[11] = '{0, 16'h00, 1, 0, 1, 1, 16'h22, 2, 3};
    tbl[12] = '{0, 16'h00, 1, 0, 1, 1, 16'h33, 1, 3};
    tbl[13] = '{0, 16'h00, 1, 0, 1, 0, 16'h00, 0, 3};
    tbl[14] = '{0, 16'h00, 1, 1, 1, 0, 16'h00, 0, 3};
    tbl[15] = '{0, 16'h00, 1, 0, 1, 0, 16'h00, 0, 0};

    do_reset();

    // Directed table: single beat latency, stall/backpressure, drain, clear.
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      io.m_valid = tbl[r].mv; io.m_data = tbl[r].d;
      io.s_ready = tbl[r].sr; clr_cnt = tbl[r].clr;
      #1;
      chk($sformatf("tbl%0d_m_ready", r), 32'(io.m_ready), 32'(tbl[r].e_mr));
      chk($sformatf("tbl%0d_s_valid", r), 32'(io.s_valid), 32'(tbl[r].e_sv));
      chk($sformatf("tbl%0d_occ", r), 32'(occupancy), 32'(tbl[r].e_occ));
      chk($sformatf("tbl%0d_stall", r), 32'(stall_cnt), 32'(tbl[r].e_st));
      if (tbl[r].e_sv)
        chk($sformatf("tbl%0d_s_data", r), 32'(io.s_data), 32'(tbl[r].e_sd));
`ifdef AVR_FRS_DATA_CLR_EN
      else
        chk($sformatf("tbl%0d_s_data_clr", r), 32'(io.s_data), 32'h0);
`endif
    end

    // Back-to-back stream 0x01..0x10 with s_ready held high.
    nxt = 1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      io.m_valid = (c < 16); io.m_data = 16'(c + 1); io.s_ready = 1'b1; clr_cnt = 1'b0;
      #1;
      if (io.s_valid) begin
        chk("stream_data", 32'(io.s_data), 32'(nxt));
        nxt++;
      end else if (nxt > 1 && nxt <= 16) begin
        chk("stream_gap", 32'(io.s_valid), 32'h1);
      end
      if (c >= 2 && c <= 16)
        chk("stream_occ", 32'(occupancy), 32'(STAGES));
    end
    chk("stream_count", 32'(nxt - 1), 32'd16);

    // Stall counter saturation and clear while still stalled.
    @(negedge clk);
    io.m_valid = 1'b0; io.s_ready = 1'b1; clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0; io.m_valid = 1'b1; io.m_data = 16'h55; io.s_ready = 1'b0;
    #1;
    for (int w = 0; w < 10 && !io.s_valid; w++) begin
      @(negedge clk);
      io.m_valid = 1'b0;
      #1;
    end
    chk("sat_wait_valid", 32'(io.s_valid), 32'h1);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("sat_k%0d", k), 32'(stall_cnt), 32'(k < 15 ? k : 15));
      chk("sat_hold_data", 32'(io.s_data), 32'h55);
      @(negedge clk);
      #1;
    end
    clr_cnt = 1'b1;
    chk("sat_top", 32'(stall_cnt), 32'd15);
    @(negedge clk);
    clr_cnt = 1'b0;
    #1;
    chk("sat_clr0", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    #1;
    chk("sat_clr1", 32'(stall_cnt), 32'd1);
    @(negedge clk);
    io.s_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset with a full pipe: outputs clear at once, only new beats follow.
    io.m_valid = 1'b1; io.m_data = 16'h77; io.s_ready = 1'b0;
    @(negedge clk);
    io.m_data = 16'h88;
    @(negedge clk);
    io.m_valid = 1'b0;
    #1;
    chk("rst_pre_occ", 32'(occupancy), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_s_valid", 32'(io.s_valid), 32'h0);
    chk("rst_s_data", 32'(io.s_data), 32'h0);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    chk("rst_m_ready", 32'(io.m_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1; io.m_valid = 1'b1; io.m_data = 16'h99; io.s_ready = 1'b1;
    @(negedge clk);
    io.m_valid = 1'b0;
    seen = 0;
    for (int w = 0; w < 6; w++) begin
      #1;
      if (io.s_valid) begin
        seen++;
        chk("rst_new_beat", 32'(io.s_data), 32'h99);
      end
      @(negedge clk);
    end
    chk("rst_beat_count", 32'(seen), 32'd1);

    // Randomized traffic against a queue scoreboard.
    do_reset();
    acc_cnt = 0; out_cnt = 0; cyc = 0; exp_st = 0; prev_hold = 1'b0; prev_d = '0;
    while (out_cnt < NBEATS && cyc < 60000) begin
      @(negedge clk);
      io.m_valid = (acc_cnt < NBEATS) ? 1'($urandom_range(0, 1)) : 1'b0;
      io.m_data  = 16'($urandom);
      io.s_ready = 1'($urandom_range(0, 1));
      clr_cnt    = ($urandom_range(0, 63) == 0);
      #1;
      exp_occ = q.size();
      chk("rnd_occ", 32'(occupancy), 32'(exp_occ));
      chk("rnd_stall", 32'(stall_cnt), 32'(exp_st));
      chk("rnd_m_ready", 32'(io.m_ready), 32'((exp_occ < STAGES) || io.s_ready));
      if (prev_hold) begin
        chk("rnd_hold_valid", 32'(io.s_valid), 32'h1);
        chk("rnd_hold_data", 32'(io.s_data), 32'(prev_d));
      end
`ifdef AVR_FRS_DATA_CLR_EN
      if (!io.s_valid)
        chk("rnd_data_clr", 32'(io.s_data), 32'h0);
`endif
      if (io.s_valid && io.s_ready) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_beat", 32'(io.s_valid), 32'h0);
        end else begin
          exp_d = q.pop_front();
          chk("rnd_data", 32'(io.s_data), 32'(exp_d));
        end
        out_cnt++;
      end
      if (io.m_valid && io.m_ready) begin
        q.push_back(io.m_data);
        acc_cnt++;
      end
      if (clr_cnt)
        exp_st = 0;
      else if (io.s_valid && !io.s_ready && exp_st < (1 << CNT_W) - 1)
        exp_st++;
      prev_hold = io.s_valid && !io.s_ready;
      prev_d    = io.s_data;
      cyc++;
    end
    chk("rnd_beats_out", 32'(out_cnt), 32'(NBEATS));
    chk("rnd_queue_empty", 32'(q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
